// File: rtl/uart_parity_engine.sv
// uart_parity_engine: TX parity generation with frame-error injection, RX parity check with saturating error count.
module uart_parity_engine #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int INJ_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              par_en,
  input  logic [1:0]        par_mode,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_par,
  output logic              tx_par_vld,
  input  logic              inj_req,
  input  logic [INJ_W-1:0]  inj_num,
  output logic              inj_busy,
  output logic              inj_done,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_par,
  output logic              rx_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);
  typedef enum logic [1:0] {IDLE, ARMED, FINISH} state_t;
  state_t             state_q, state_d;
  logic [INJ_W-1:0]   rem_q, rem_d;
  logic               tx_par_q, tx_par_d, tx_par_vld_q, tx_par_vld_d;
  logic               inj_busy_q, inj_busy_d, inj_done_q, inj_done_d;
  logic               rx_err_q, rx_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               corrupt;

  function automatic logic par_f(input logic [DATA_W-1:0] d, input logic [1:0] m);
    return m[1] ? ~m[0] : (^d ^ m[0]);
  endfunction

  always_comb begin
    corrupt      = state_q == ARMED && tx_load && par_en;
    tx_par_vld_d = tx_load;
    tx_par_d     = tx_load ? (par_en & (par_f(tx_data, par_mode) ^ corrupt)) : tx_par_q;
    state_d      = state_q;
    rem_d        = rem_q;
    inj_done_d   = 1'b0;
    if (state_q == IDLE && inj_req && inj_num != '0) begin
      state_d = ARMED;
      rem_d   = inj_num;
    end else if (corrupt) begin
      rem_d = rem_q - 1'b1;
      if (rem_q == INJ_W'(1)) begin
        state_d    = FINISH;
        inj_done_d = 1'b1;
      end
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end
    inj_busy_d = state_d != IDLE;
    // the clear wins over a coincident increment, but the error pulse still fires
    rx_err_d   = rx_valid && par_en && (rx_par != par_f(rx_data, par_mode));
    err_cnt_d  = cnt_clr ? '0 : (rx_err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      tx_par_q     <= 1'b0;
      tx_par_vld_q <= 1'b0;
      inj_busy_q   <= 1'b0;
      inj_done_q   <= 1'b0;
      rx_err_q     <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      tx_par_q     <= tx_par_d;
      tx_par_vld_q <= tx_par_vld_d;
      inj_busy_q   <= inj_busy_d;
      inj_done_q   <= inj_done_d;
      rx_err_q     <= rx_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign tx_par     = tx_par_q;
  assign tx_par_vld = tx_par_vld_q;
  assign inj_busy   = inj_busy_q;
  assign inj_done   = inj_done_q;
  assign rx_err     = rx_err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_uart_parity_engine.sv
// tb_uart_parity_engine: directed checks of TX parity, injection FSM, RX checking and reset abort.
module tb_uart_parity_engine;
  logic       CLK = 0, RST = 0;
  logic       par_en = 0, tx_load = 0, inj_req = 0, rx_valid = 0, rx_par = 0, cnt_clr = 0;
  logic [1:0] par_mode = 0;
  logic [7:0] tx_data = 0, rx_data = 0;
  logic [3:0] inj_num = 0;
  logic       tx_par, tx_par_vld, inj_busy, inj_done, rx_err;
  logic [1:0] err_cnt;
  int         tests = 0, fails = 0;

  uart_parity_engine #(.DATA_W(8), .CNT_W(2), .INJ_W(4)) dut (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
    .tx_load(tx_load), .tx_data(tx_data), .tx_par(tx_par), .tx_par_vld(tx_par_vld),
    .inj_req(inj_req), .inj_num(inj_num), .inj_busy(inj_busy), .inj_done(inj_done),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_par(rx_par), .rx_err(rx_err),
    .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    tx_load = 0; inj_req = 0; rx_valid = 0; cnt_clr = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_par"}, 32'(tx_par), 0);
    chk({tag, "_vld"}, 32'(tx_par_vld), 0);
    chk({tag, "_busy"}, 32'(inj_busy), 0);
    chk({tag, "_done"}, 32'(inj_done), 0);
    chk({tag, "_rxerr"}, 32'(rx_err), 0);
    chk({tag, "_cnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    tick(); tick();
    chk_zero("rst");
    RST = 1;
    par_en = 1; par_mode = 0;
    tx_load = 1; tx_data = 8'hA5; tick();
    chk("even_a5_vld", 32'(tx_par_vld), 1);
    chk("even_a5", 32'(tx_par), 0);
    par_mode = 1; tx_load = 1; tick();
    chk("odd_a5", 32'(tx_par), 1);
    tick();
    chk("vld_pulse", 32'(tx_par_vld), 0);
    chk("par_hold", 32'(tx_par), 1);
    par_mode = 2; tx_load = 1; tx_data = 8'h00; tick();
    chk("mark", 32'(tx_par), 1);
    par_mode = 3; tx_load = 1; tx_data = 8'hFF; tick();
    chk("space", 32'(tx_par), 0);
    par_mode = 0;
    inj_req = 1; inj_num = 0; tick();
    chk("inj_zero_ign", 32'(inj_busy), 0);
    inj_req = 1; inj_num = 2; tick();
    chk("inj_arm_busy", 32'(inj_busy), 1);
    tx_load = 1; tx_data = 8'h07; tick();
    chk("inj1_par", 32'(tx_par), 0);
    chk("inj1_done", 32'(inj_done), 0);
    tx_load = 1; tick();
    chk("inj2_par", 32'(tx_par), 0);
    chk("inj2_vld", 32'(tx_par_vld), 1);
    chk("inj2_done", 32'(inj_done), 1);
    chk("inj2_busy", 32'(inj_busy), 1);
    tx_load = 1; tick();
    chk("inj3_par", 32'(tx_par), 1);
    chk("inj3_done", 32'(inj_done), 0);
    chk("inj3_busy", 32'(inj_busy), 0);
    inj_req = 1; inj_num = 1; tx_load = 1; tick();
    chk("arm_load_par", 32'(tx_par), 1);
    chk("arm_load_busy", 32'(inj_busy), 1);
    inj_req = 1; inj_num = 5; tick();
    tx_load = 1; tick();
    chk("rearm_ign_par", 32'(tx_par), 0);
    chk("rearm_ign_done", 32'(inj_done), 1);
    tick();
    chk("rearm_ign_busy", 32'(inj_busy), 0);
    rx_valid = 1; rx_data = 8'h07; rx_par = 0; tick();
    chk("rx_bad_err", 32'(rx_err), 1);
    chk("rx_bad_cnt", 32'(err_cnt), 1);
    rx_valid = 1; rx_par = 1; tick();
    chk("rx_ok_err", 32'(rx_err), 0);
    chk("rx_ok_cnt", 32'(err_cnt), 1);
    cnt_clr = 1; tick();
    chk("clr_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1; rx_par = 0; tick();
      chk("sat_err", 32'(rx_err), 1);
      chk("sat_cnt", 32'(i < 3 ? i + 1 : 3), 32'(err_cnt));
    end
    rx_valid = 1; rx_par = 0; cnt_clr = 1; tx_load = 1; tx_data = 8'hA5; tick();
    chk("clr_win_err", 32'(rx_err), 1);
    chk("clr_win_cnt", 32'(err_cnt), 0);
    chk("tx_rx_vld", 32'(tx_par_vld), 1);
    chk("tx_rx_par", 32'(tx_par), 0);
    par_mode = 3; rx_valid = 1; rx_data = 8'h00; rx_par = 1; tick();
    chk("rx_space_err", 32'(rx_err), 1);
    par_mode = 0;
    inj_req = 1; inj_num = 3; tick();
    tx_load = 1; tx_data = 8'h07; tick();
    chk("abort_first", 32'(tx_par), 0);
    RST = 0; #1;
    chk_zero("abort");
    tick();
    chk("abort_done", 32'(inj_done), 0);
    RST = 1;
    tx_load = 1; tx_data = 8'hA5; tick();
    chk("post_rst_par", 32'(tx_par), 0);
    chk("post_rst_busy", 32'(inj_busy), 0);
    chk("post_rst_done", 32'(inj_done), 0);
    par_en = 0;
    inj_req = 1; inj_num = 1; tick();
    tx_load = 1; tx_data = 8'hA5; tick();
    chk("dis_par", 32'(tx_par), 0);
    chk("dis_vld", 32'(tx_par_vld), 1);
    chk("dis_busy", 32'(inj_busy), 1);
    rx_valid = 1; rx_data = 8'h07; rx_par = 0; tick();
    chk("dis_rxerr", 32'(rx_err), 0);
    par_en = 1; tx_load = 1; tx_data = 8'hA5; tick();
    chk("en_par", 32'(tx_par), 1);
    chk("en_done", 32'(inj_done), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
